// File: rtl/grid_bulk_loader.sv
`default_nettype none
// ============================================================================
// Module      : grid_bulk_loader
// Description : Receives framed bytes from a serial RX stream and writes the
//               payload into memory as little-endian words.
//               Frame: 0xA5, LEN_LO, LEN_HI (word count N), N*BYTES data
//               bytes, one XOR checksum byte covering the data bytes only.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid/in_data     - upstream byte stream
//               in_ready             - byte accepted when valid && ready
//               abort                - synchronous frame abort
//               mem_addr/mem_w_data  - memory write address / data
//               mem_we               - one-cycle write strobe per word
//               busy                 - a frame is in progress
//               done / err           - one-cycle frame result pulses
// Revision    : 1.0 - initial release
// ============================================================================
module grid_bulk_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int             BYTES     = DATA_WIDTH / 8;
  localparam int             BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [7:0]     SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [15:0]             len;
  logic [15:0]             word_idx;
  logic [16:0]             word_idx_inc;
  logic [BCW-1:0]          byte_cnt;
  logic [DATA_WIDTH-1:0]   assembly;
  logic [DATA_WIDTH-1:0]   word_full;
  logic [7:0]              csum;
  logic                    accept;

  assign accept       = in_valid && in_ready;
  // One extra bit so that N = 0xFFFF still compares correctly.
  assign word_idx_inc = {1'b0, word_idx} + 17'd1;

  // Current partial word with the incoming byte merged into its lane.
  always_comb begin
    word_full = assembly;
    word_full[int'(byte_cnt) * 8 +: 8] = in_data;
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    in_ready   = (state != S_WRITE);
    mem_we     = (state == S_WRITE) && !abort;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_next = ({in_data, len[7:0]} == 16'd0) ? S_CSUM : S_DATA;
      end
      S_DATA: begin
        if (accept && (byte_cnt == LAST_BYTE)) state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = (word_idx_inc < {1'b0, len}) ? S_DATA : S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  // State register and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      assembly   <= '0;
      csum       <= '0;
      mem_addr   <= '0;
      mem_w_data <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      err   <= 1'b0;
      // An aborted cycle discards its byte and leaves the datapath untouched.
      if (!abort) begin
        unique case (state)
          S_IDLE: begin
            if (accept && (in_data == SYNC_BYTE)) begin
              csum     <= '0;
              word_idx <= '0;
              byte_cnt <= '0;
            end
          end
          S_LEN_LO: begin
            if (accept) len[7:0] <= in_data;
          end
          S_LEN_HI: begin
            if (accept) len[15:8] <= in_data;
          end
          S_DATA: begin
            if (accept) begin
              csum     <= csum ^ in_data;
              assembly <= word_full;
              if (byte_cnt == LAST_BYTE) begin
                // Load the write port on entry to WRITE; it then holds
                // until the next word completes.
                byte_cnt   <= '0;
                mem_w_data <= word_full;
                mem_addr   <= word_idx[ADDR_WIDTH-1:0];
              end else begin
                byte_cnt <= byte_cnt + BCW'(1);
              end
            end
          end
          S_WRITE: begin
            word_idx <= word_idx_inc[15:0];
          end
          S_CSUM: begin
            if (accept) begin
              done <= (in_data == csum);
              err  <= (in_data != csum);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grid_bulk_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_bulk_loader
// Description : Self-checking bench for grid_bulk_loader (ADDR_WIDTH=2,
//               DATA_WIDTH=32). Per-cycle vector table plus hand sequences
//               for address wrap/throughput and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_bulk_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        abort;
  logic [1:0]  mem_addr;
  logic [31:0] mem_w_data;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int passes = 0;

  grid_bulk_loader #(
    .ADDR_WIDTH(2),
    .DATA_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .abort     (abort),
    .mem_addr  (mem_addr),
    .mem_w_data(mem_w_data),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ab;
    logic        rdy;
    logic        we;
    logic        bsy;
    logic        dn;
    logic        er;
    logic [1:0]  addr;
    logic [31:0] wd;
  } vec_t;

  vec_t vec_q[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic ab, logic rdy, logic we,
                              logic bsy, logic dn, logic er, logic [1:0] addr,
                              logic [31:0] wd);
    vec_t t;
    t.v = v; t.d = d; t.ab = ab; t.rdy = rdy; t.we = we; t.bsy = bsy;
    t.dn = dn; t.er = er; t.addr = addr; t.wd = wd;
    return t;
  endfunction

  function automatic void add(logic v, logic [7:0] d, logic ab, logic rdy, logic we,
                              logic bsy, logic dn, logic er, logic [1:0] addr,
                              logic [31:0] wd);
    vec_q.push_back(mk(v, d, ab, rdy, we, bsy, dn, er, addr, wd));
  endfunction

  // Two-word frame 11 22 33 44 / 55 66 77 88 with the given checksum byte.
  function automatic void add_n2(logic [7:0] cs, logic good, logic [1:0] pa, logic [31:0] pw);
    logic [7:0] w0 [4];
    logic [7:0] w1 [3];
    w0[0] = 8'h11; w0[1] = 8'h22; w0[2] = 8'h33; w0[3] = 8'h44;
    w1[0] = 8'h66; w1[1] = 8'h77; w1[2] = 8'h88;
    add(1, 8'hA5, 0, 1, 0, 0, 0, 0, pa, pw);
    add(1, 8'h02, 0, 1, 0, 1, 0, 0, pa, pw);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, pa, pw);
    for (int i = 0; i < 4; i++) add(1, w0[i], 0, 1, 0, 1, 0, 0, pa, pw);
    add(1, 8'h55, 0, 0, 1, 1, 0, 0, 2'd0, 32'h44332211);  // WRITE: byte held off
    add(1, 8'h55, 0, 1, 0, 1, 0, 0, 2'd0, 32'h44332211);
    for (int i = 0; i < 3; i++) add(1, w1[i], 0, 1, 0, 1, 0, 0, 2'd0, 32'h44332211);
    add(0, 8'h00, 0, 0, 1, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, cs,    0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(0, 8'h00, 0, 1, 0, 0, good, !good, 2'd1, 32'h88776655);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 2'd1, 32'h88776655);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, advance past the edge.
  task automatic run_vec(input vec_t t, input int n);
    in_valid = t.v;
    in_data  = t.d;
    abort    = t.ab;
    @(negedge clk);
    chk($sformatf("vec%0d", n),
        64'({in_ready, mem_we, busy, done, err, mem_addr, mem_w_data}),
        64'({t.rdy, t.we, t.bsy, t.dn, t.er, t.addr, t.wd}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  stream [$];
    logic [1:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_time [$];
    int          idx;
    int          cyc;
    int          ready_bad;
    int          we_cnt;
    int          busy_cnt;
    logic [31:0] exp_w;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    abort    = 1'b0;

    // ---------------- reset state ----------------
    #12;
    chk("reset_outputs", 64'({mem_we, busy, done, err, mem_addr, mem_w_data}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset", 64'({in_ready, mem_we, busy, done, err, mem_addr, mem_w_data}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0}));
    @(posedge clk);
    #1;

    // ---------------- vector table ----------------
    add_n2(8'h88, 1'b1, 2'd0, 32'h0);                 // good checksum
    add_n2(8'h00, 1'b0, 2'd1, 32'h88776655);          // bad checksum
    // Junk before sync, then an empty frame.
    add(1, 8'h12, 0, 1, 0, 0, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h34, 0, 1, 0, 0, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'hA5, 0, 1, 0, 0, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(0, 8'h00, 0, 1, 0, 0, 1, 0, 2'd1, 32'h88776655);
    // Abort in DATA after two bytes, then a fresh frame writes at address 0.
    add(1, 8'hA5, 0, 1, 0, 0, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h01, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h11, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h22, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h33, 1, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'hA5, 0, 1, 0, 0, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h01, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'hAA, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'hBB, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'hCC, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(1, 8'hDD, 0, 1, 0, 1, 0, 0, 2'd1, 32'h88776655);
    add(0, 8'h00, 0, 0, 1, 1, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(0, 8'h00, 0, 1, 0, 0, 1, 0, 2'd0, 32'hDDCCBBAA);
    // Abort landing on the WRITE cycle suppresses the strobe.
    add(1, 8'hA5, 0, 1, 0, 0, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(1, 8'h01, 0, 1, 0, 1, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(1, 8'h01, 0, 1, 0, 1, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(1, 8'h02, 0, 1, 0, 1, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(1, 8'h03, 0, 1, 0, 1, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(1, 8'h04, 0, 1, 0, 1, 0, 0, 2'd0, 32'hDDCCBBAA);
    add(1, 8'h00, 1, 0, 0, 1, 0, 0, 2'd0, 32'h04030201);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 2'd0, 32'h04030201);
    // 0xA5 inside DATA and as checksum is payload, not resync.
    add(1, 8'hA5, 0, 1, 0, 0, 0, 0, 2'd0, 32'h04030201);
    add(1, 8'h01, 0, 1, 0, 1, 0, 0, 2'd0, 32'h04030201);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd0, 32'h04030201);
    add(1, 8'hA5, 0, 1, 0, 1, 0, 0, 2'd0, 32'h04030201);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd0, 32'h04030201);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd0, 32'h04030201);
    add(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd0, 32'h04030201);
    add(0, 8'h00, 0, 0, 1, 1, 0, 0, 2'd0, 32'h000000A5);
    add(1, 8'hA5, 0, 1, 0, 1, 0, 0, 2'd0, 32'h000000A5);
    add(0, 8'h00, 0, 1, 0, 0, 1, 0, 2'd0, 32'h000000A5);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 2'd0, 32'h000000A5);

    for (int i = 0; i < vec_q.size(); i++) run_vec(vec_q[i], i);

    // ---------------- address wrap + throughput (N=5, valid held) ----------------
    stream.push_back(8'hA5);
    stream.push_back(8'h05);
    stream.push_back(8'h00);
    for (int i = 0; i < 20; i++) stream.push_back(8'(i));
    stream.push_back(8'h00);  // XOR of 0..19 is 0
    idx       = 0;
    cyc       = 0;
    ready_bad = 0;
    while (idx < stream.size() && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = stream[idx];
      @(negedge clk);
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_w_data);
        wr_time.push_back(cyc);
      end
      if (in_ready == mem_we) ready_bad++;
      if (in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_finished", 64'(idx), 64'(stream.size()));
    @(negedge clk);
    chk("wrap_done", 64'({done, err}), 64'({1'b1, 1'b0}));
    @(posedge clk);
    #1;
    chk("wrap_write_count", 64'(wr_addr.size()), 64'd5);
    chk("wrap_ready_low_on_write", 64'(ready_bad), 64'd0);
    if (wr_addr.size() == 5) begin
      chk("wrap_addr_seq", 64'({wr_addr[0], wr_addr[1], wr_addr[2], wr_addr[3], wr_addr[4]}),
          64'({2'd0, 2'd1, 2'd2, 2'd3, 2'd0}));
      for (int w = 0; w < 5; w++) begin
        exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        chk($sformatf("wrap_data%0d", w), 64'(wr_data[w]), 64'(exp_w));
      end
      for (int w = 1; w < 5; w++)
        chk($sformatf("wrap_interval%0d", w), 64'(wr_time[w] - wr_time[w-1]), 64'd5);
    end

    // ---------------- reset mid-DATA with valid held ----------------
    run_vec(mk(1, 8'hA5, 0, 1, 0, 0, 0, 0, 2'd0, 32'h13121110), 1000);
    run_vec(mk(1, 8'h02, 0, 1, 0, 1, 0, 0, 2'd0, 32'h13121110), 1001);
    run_vec(mk(1, 8'h00, 0, 1, 0, 1, 0, 0, 2'd0, 32'h13121110), 1002);
    run_vec(mk(1, 8'h11, 0, 1, 0, 1, 0, 0, 2'd0, 32'h13121110), 1003);
    run_vec(mk(1, 8'h22, 0, 1, 0, 1, 0, 0, 2'd0, 32'h13121110), 1004);
    in_valid = 1'b1;
    in_data  = 8'h33;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({in_ready, mem_we, busy, done, err, mem_addr, mem_w_data}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0}));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    we_cnt   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'(8'h33 + i);
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("post_reset_no_write", 64'(we_cnt), 64'd0);
    chk("post_reset_idle", 64'(busy_cnt), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
